// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Purpose:
//   Sequences one instruction-style request at a time through an external
//   combinational ALU. A request is decoded and registered on accept (IDLE).
//   During a single EXEC cycle the registered operands and opcode drive the ALU.
//   The ALU result and flags are captured at the end of EXEC. The response is
//   then held in DONE until the consumer takes it. Branch requests are
//   evaluated as a SUB, and taken/not-taken is derived from the captured flags.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    request handshake (in_ready high only in IDLE)
//   funct3, funct7_5,      operation select
//   is_imm, is_branch
//   rs1, rs2, imm          operands
//   alu_a, alu_b,          operands and opcode presented to the ALU
//   alu_opcode
//   alu_result, alu_status ALU result and {N,Z,C,V} flags
//   out_valid / out_ready  response handshake
//   out_result, out_flags, response payload
//   branch_taken, illegal
//   op_count               count of completed responses (wraps at 16 bits)
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int C_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         funct3,
    input  logic               funct7_5,
    input  logic               is_imm,
    input  logic               is_branch,
    input  logic [C_WIDTH-1:0] rs1,
    input  logic [C_WIDTH-1:0] rs2,
    input  logic [C_WIDTH-1:0] imm,
    output logic [C_WIDTH-1:0] alu_a,
    output logic [C_WIDTH-1:0] alu_b,
    output logic [3:0]         alu_opcode,
    input  logic [C_WIDTH-1:0] alu_result,
    input  logic [3:0]         alu_status,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [C_WIDTH-1:0] out_result,
    output logic [3:0]         out_flags,
    output logic               branch_taken,
    output logic               illegal,
    output logic [15:0]        op_count
);

    localparam int SHAMT_W = $clog2(C_WIDTH);
    localparam logic [C_WIDTH-1:0] SHAMT_MASK = C_WIDTH'((2 ** SHAMT_W) - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [C_WIDTH-1:0] a_q;
    logic [C_WIDTH-1:0] b_q, b_d;
    logic [3:0]         opc_q, opc_d;
    logic [2:0]         f3_q;
    logic               br_q;
    logic [C_WIDTH-1:0] result_q;
    logic [3:0]         flags_q;
    logic               taken_q, taken_d;
    logic               illegal_q, illegal_d;
    logic               accept;

    assign accept = in_valid && (state_q == S_IDLE);

    // Request decode, evaluated on the live inputs and registered on accept.
    always_comb begin
        opc_d = OP_ADD;
        b_d   = rs2;
        if (is_branch) begin
            // Branches always compare rs1 against rs2, whatever is_imm says.
            opc_d = OP_SUB;
            b_d   = rs2;
        end else begin
            b_d = is_imm ? imm : rs2;
            case (funct3)
                3'b000: opc_d = (funct7_5 && !is_imm) ? OP_SUB : OP_ADD;
                3'b001: begin
                    opc_d = OP_SLL;
                    b_d   = b_d & SHAMT_MASK;
                end
                3'b010: opc_d = OP_SLT;
                3'b011: opc_d = OP_SLTU;
                3'b100: opc_d = OP_XOR;
                3'b101: begin
                    opc_d = funct7_5 ? OP_SRA : OP_SRL;
                    b_d   = b_d & SHAMT_MASK;
                end
                3'b110: opc_d = OP_OR;
                default: opc_d = OP_AND;
            endcase
        end
    end

    // Branch outcome from the flags being captured this cycle ({N,Z,C,V}).
    // C means "borrow" for SUB, so it flags rs1 < rs2 unsigned.
    always_comb begin
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        if (br_q) begin
            case (f3_q)
                3'b000:  taken_d = alu_status[2];
                3'b001:  taken_d = !alu_status[2];
                3'b100:  taken_d = alu_status[3] ^ alu_status[0];
                3'b101:  taken_d = !(alu_status[3] ^ alu_status[0]);
                3'b110:  taken_d = alu_status[1];
                3'b111:  taken_d = !alu_status[1];
                default: illegal_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_EXEC;
            S_EXEC: state_d = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opc_q     <= '0;
            f3_q      <= '0;
            br_q      <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                a_q   <= rs1;
                b_q   <= b_d;
                opc_q <= opc_d;
                f3_q  <= funct3;
                br_q  <= is_branch;
            end
            if (state_q == S_EXEC) begin
                result_q  <= alu_result;
                flags_q   <= alu_status;
                taken_q   <= taken_d;
                illegal_q <= illegal_d;
            end
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_opcode   = opc_q;
    assign out_result   = result_q;
    assign out_flags    = flags_q;
    assign branch_taken = taken_q;
    assign illegal      = illegal_q;
    assign op_count     = cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Directed testbench for alu_sequencer (C_WIDTH = 8). A small behavioural ALU
// closes the loop between alu_a/alu_b/alu_opcode and alu_result/alu_status.
// Inputs are driven 1 ns after the rising edge. Outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   funct3 = 3'b000;
    logic         funct7_5 = 1'b0;
    logic         is_imm = 1'b0;
    logic         is_branch = 1'b0;
    logic [W-1:0] rs1 = '0;
    logic [W-1:0] rs2 = '0;
    logic [W-1:0] imm = '0;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_result;
    logic [3:0]   alu_status;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic [3:0]   out_flags;
    logic         branch_taken;
    logic         illegal;
    logic [15:0]  op_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    alu_sequencer #(.C_WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .is_imm       (is_imm),
        .is_branch    (is_branch),
        .rs1          (rs1),
        .rs2          (rs2),
        .imm          (imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_status   (alu_status),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .branch_taken (branch_taken),
        .illegal      (illegal),
        .op_count     (op_count)
    );

    // Behavioural ALU: flags are {N,Z,C,V}; C is carry for ADD, borrow for SUB.
    always_comb begin
        logic c, v;
        logic [W-1:0] r;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (alu_opcode)
            4'b0000: begin
                {c, r} = {1'b0, alu_a} + {1'b0, alu_b};
                v = (alu_a[W-1] == alu_b[W-1]) && (r[W-1] != alu_a[W-1]);
            end
            4'b0001: begin
                r = alu_a - alu_b;
                c = alu_a < alu_b;
                v = (alu_a[W-1] != alu_b[W-1]) && (r[W-1] != alu_a[W-1]);
            end
            4'b0010: r = alu_a & alu_b;
            4'b0011: r = alu_a | alu_b;
            4'b0100: r = alu_a ^ alu_b;
            4'b0101: r = {{(W-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            4'b0111: r = {{(W-1){1'b0}}, alu_a < alu_b};
            4'b1000: r = alu_a << alu_b[2:0];
            4'b1001: r = alu_a >> alu_b[2:0];
            4'b1011: r = W'($signed(alu_a) >>> alu_b[2:0]);
            default: r = '0;
        endcase
        alu_result = r;
        alu_status = {r[W-1], (r == '0), c, v};
    end

    // Present a request and return 1 ns after the accept edge (DUT in EXEC).
    // The request inputs are then scrambled, so late input changes are exercised.
    task automatic start_req(input logic [2:0] f3, input logic f7, input logic im,
                             input logic br, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] i);
        funct3 = f3; funct7_5 = f7; is_imm = im; is_branch = br;
        rs1 = a; rs2 = b; imm = i;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        funct3 = ~f3; funct7_5 = ~f7; is_imm = ~im; is_branch = ~br;
        rs1 = 8'hA5; rs2 = 8'h5A; imm = 8'hC3;
    endtask

    // Move from EXEC to DONE.
    task automatic step;
        @(posedge clk); #1;
    endtask

    // Complete the handshake from DONE.
    task automatic finish_req;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++;
        if ({out_result, out_flags, branch_taken, illegal} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_payload got=%h/%b/%b/%b exp=0", out_result, out_flags, branch_taken, illegal);
        end
        n_cmp++; if (op_count !== 16'd0) begin n_bad++; $display("FAIL reset_op_count got=%h exp=0", op_count); end
        n_cmp++;
        if ({alu_a, alu_b, alu_opcode} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_alu_regs got=%h/%h/%b exp=0", alu_a, alu_b, alu_opcode);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add;
        start_req(3'b000, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h00);
        n_cmp++; if (alu_opcode !== 4'b0000) begin n_bad++; $display("FAIL add_opcode got=%b exp=0000", alu_opcode); end
        n_cmp++; if ({alu_a, alu_b} !== 16'h7F01) begin n_bad++; $display("FAIL add_operands got=%h/%h exp=7f/01", alu_a, alu_b); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_exec_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL add_exec_ready got=%b exp=0", in_ready); end
        step;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_done_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_result !== 8'h80) begin n_bad++; $display("FAIL add_result got=%h exp=80", out_result); end
        n_cmp++; if (out_flags !== 4'b1001) begin n_bad++; $display("FAIL add_flags got=%b exp=1001", out_flags); end
        n_cmp++; if ({branch_taken, illegal} !== 2'b00) begin n_bad++; $display("FAIL add_br_ill got=%b exp=00", {branch_taken, illegal}); end
        finish_req;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_after_valid got=%b exp=0", out_valid); end
        n_cmp++; if (op_count !== exp_cnt) begin n_bad++; $display("FAIL add_op_count got=%h exp=%h", op_count, exp_cnt); end
    endtask

    task automatic test_sub;
        start_req(3'b000, 1'b1, 1'b0, 1'b0, 8'h05, 8'h05, 8'h00);
        n_cmp++; if (alu_opcode !== 4'b0001) begin n_bad++; $display("FAIL sub_opcode got=%b exp=0001", alu_opcode); end
        step;
        n_cmp++; if (out_result !== 8'h00) begin n_bad++; $display("FAIL sub_result got=%h exp=00", out_result); end
        n_cmp++; if (out_flags !== 4'b0100) begin n_bad++; $display("FAIL sub_flags got=%b exp=0100", out_flags); end
        n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL sub_taken got=%b exp=0", branch_taken); end
        finish_req;
        // funct7_5 with is_imm is ADDI, not SUB: 0x05 + 0x03.
        start_req(3'b000, 1'b1, 1'b1, 1'b0, 8'h05, 8'h05, 8'h03);
        n_cmp++; if ({alu_opcode, alu_b} !== 12'h003) begin n_bad++; $display("FAIL addi_decode got=%b/%h exp=0000/03", alu_opcode, alu_b); end
        step;
        n_cmp++; if (out_result !== 8'h08) begin n_bad++; $display("FAIL addi_result got=%h exp=08", out_result); end
        finish_req;
    endtask

    task automatic test_shift;
        start_req(3'b001, 1'b0, 1'b1, 1'b0, 8'h41, 8'hFF, 8'h09);
        n_cmp++; if (alu_b !== 8'h01) begin n_bad++; $display("FAIL slli_alu_b got=%h exp=01", alu_b); end
        n_cmp++; if (alu_opcode !== 4'b1000) begin n_bad++; $display("FAIL slli_opcode got=%b exp=1000", alu_opcode); end
        step;
        n_cmp++; if (out_result !== 8'h82) begin n_bad++; $display("FAIL slli_result got=%h exp=82", out_result); end
        finish_req;
        start_req(3'b101, 1'b1, 1'b1, 1'b0, 8'h80, 8'h00, 8'h0A);
        n_cmp++; if ({alu_opcode, alu_b} !== 12'hB02) begin n_bad++; $display("FAIL srai_decode got=%b/%h exp=1011/02", alu_opcode, alu_b); end
        step;
        n_cmp++; if (out_result !== 8'hE0) begin n_bad++; $display("FAIL srai_result got=%h exp=e0", out_result); end
        finish_req;
        start_req(3'b101, 1'b0, 1'b0, 1'b0, 8'h80, 8'h0C, 8'h00);
        n_cmp++; if ({alu_opcode, alu_b} !== 12'h904) begin n_bad++; $display("FAIL srl_decode got=%b/%h exp=1001/04", alu_opcode, alu_b); end
        step;
        n_cmp++; if (out_result !== 8'h08) begin n_bad++; $display("FAIL srl_result got=%h exp=08", out_result); end
        finish_req;
    endtask

    task automatic test_logic;
        logic [2:0] f3s [4] = '{3'b100, 3'b110, 3'b111, 3'b010};
        logic [3:0] ops [4] = '{4'b0100, 4'b0011, 4'b0010, 4'b0101};
        logic [7:0] res [4] = '{8'h66, 8'hFC, 8'h30, 8'h01};
        for (int k = 0; k < 4; k++) begin
            // rs1 = 0xF0 (negative), rs2 = 0x3C: SLT is signed, so 1.
            start_req(f3s[k], 1'b0, 1'b0, 1'b0, (k == 0) ? 8'h5A : 8'hF0, 8'h3C, 8'h00);
            n_cmp++; if (alu_opcode !== ops[k]) begin n_bad++; $display("FAIL logic_opcode[%0d] got=%b exp=%b", k, alu_opcode, ops[k]); end
            step;
            n_cmp++; if (out_result !== res[k]) begin n_bad++; $display("FAIL logic_result[%0d] got=%h exp=%h", k, out_result, res[k]); end
            finish_req;
        end
    endtask

    task automatic test_branch;
        logic [2:0] f3s [4] = '{3'b110, 3'b100, 3'b010, 3'b111};
        logic       tk  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       il  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            start_req(f3s[k], 1'b0, 1'b0, 1'b1, 8'h01, 8'hFF, 8'h00);
            n_cmp++; if (alu_opcode !== 4'b0001) begin n_bad++; $display("FAIL br_opcode[%0d] got=%b exp=0001", k, alu_opcode); end
            step;
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL br_valid[%0d] got=%b exp=1", k, out_valid); end
            n_cmp++;
            if ({branch_taken, illegal} !== {tk[k], il[k]}) begin
                n_bad++;
                $display("FAIL br_taken_ill[%0d] got=%b%b exp=%b%b", k, branch_taken, illegal, tk[k], il[k]);
            end
            finish_req;
        end
        // BEQ with is_imm set still compares against rs2.
        start_req(3'b000, 1'b0, 1'b1, 1'b1, 8'h33, 8'h33, 8'h00);
        n_cmp++; if (alu_b !== 8'h33) begin n_bad++; $display("FAIL beq_alu_b got=%h exp=33", alu_b); end
        step;
        n_cmp++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL beq_taken got=%b exp=1", branch_taken); end
        finish_req;
        // A non-branch op following a branch clears taken/illegal.
        start_req(3'b110, 1'b0, 1'b0, 1'b0, 8'h01, 8'h02, 8'h00);
        step;
        n_cmp++; if ({branch_taken, illegal} !== 2'b00) begin n_bad++; $display("FAIL nonbr_clear got=%b exp=00", {branch_taken, illegal}); end
        finish_req;
    endtask

    task automatic test_backpressure;
        start_req(3'b000, 1'b0, 1'b0, 1'b0, 8'h10, 8'h20, 8'h00);
        step;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rs1 = 8'(c); rs2 = 8'(c * 3);
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, in_ready, out_result, out_flags} !== {1'b1, 1'b0, 8'h30, 4'b0000}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d] got=%b/%b/%h/%b exp=1/0/30/0000", c, out_valid, in_ready, out_result, out_flags);
            end
            n_cmp++; if (op_count !== exp_cnt) begin n_bad++; $display("FAIL bp_count[%0d] got=%h exp=%h", c, op_count, exp_cnt); end
        end
        // in_valid is still high at the handshake edge; it must not be accepted there.
        finish_req;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_release got=%b%b exp=01", out_valid, in_ready); end
        n_cmp++; if (op_count !== exp_cnt) begin n_bad++; $display("FAIL bp_op_count got=%h exp=%h", op_count, exp_cnt); end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_exec;
        logic seen;
        start_req(3'b000, 1'b0, 1'b0, 1'b0, 8'h22, 8'h11, 8'h00);
        rst_n = 1'b0;
        exp_cnt = 16'd0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, out_result, out_flags, op_count} !== {1'b0, 1'b1, 8'h00, 4'h0, 16'h0000}) begin
            n_bad++;
            $display("FAIL rst_exec_outputs got=%b/%b/%h/%b/%h exp=0/1/00/0000/0000",
                     out_valid, in_ready, out_result, out_flags, op_count);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_opcode} !== 20'd0) begin
            n_bad++;
            $display("FAIL rst_exec_alu got=%h/%h/%b exp=0", alu_a, alu_b, alu_opcode);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        out_ready = 1'b0;
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_exec_no_response got=%b exp=0", seen); end
        start_req(3'b100, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h0F, 8'h00);
        step;
        n_cmp++; if (out_result !== 8'hF0) begin n_bad++; $display("FAIL rst_exec_new_result got=%h exp=f0", out_result); end
        finish_req;
        n_cmp++; if (op_count !== exp_cnt) begin n_bad++; $display("FAIL rst_exec_count got=%h exp=%h", op_count, exp_cnt); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_shift;
        test_logic;
        test_branch;
        test_backpressure;
        test_reset_exec;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
